// File: rtl/pet_state_ctrl.sv
// Pet life-cycle controller: debounces the play/feed buttons, generates the
// animation tick and drives health/timer/play for the display path.
module pet_state_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_CYCLES     = 25_000_000,
    parameter int DECAY_TICKS     = 20,
    parameter int PLAY_TICKS      = 6
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       btn_play,
    input  logic       btn_feed,
    output logic [1:0] health,
    output logic       timer,
    output logic       play
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int CW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam int PW = (PLAY_TICKS > 1) ? $clog2(PLAY_TICKS) : 1;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        PLAY  = 2'd1,
        DEAD  = 2'd2
    } state_e;

    // Index 0 is the play button, index 1 the feed button.
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    lvl_q, lvl_d;
    logic [1:0]    press_q, press_d;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic          timer_q, timer_d;

    state_e        state_q, state_d;
    logic [1:0]    health_q, health_d;
    logic [CW-1:0] decay_q, decay_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          play_q, play_d;

    logic          press_play, press_feed;
    logic          dec_hit, play_end;

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            lvl_q       <= 2'b11;
            press_q     <= 2'b00;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            tick_cnt_q  <= '0;
            timer_q     <= 1'b0;
            state_q     <= ALIVE;
            health_q    <= 2'd3;
            decay_q     <= '0;
            pcnt_q      <= '0;
            play_q      <= 1'b0;
        end else begin
            sync1_q     <= {btn_feed, btn_play};
            sync2_q     <= sync1_q;
            lvl_q       <= lvl_d;
            press_q     <= press_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            tick_cnt_q  <= tick_cnt_d;
            timer_q     <= timer_d;
            state_q     <= state_d;
            health_q    <= health_d;
            decay_q     <= decay_d;
            pcnt_q      <= pcnt_d;
            play_q      <= play_d;
        end
    end

    // Level flips only after a full run of disagreeing samples.
    always_comb begin
        lvl_d   = lvl_q;
        press_d = 2'b00;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_d[i]   = sync2_q[i];
                    press_d[i] = ~sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        tick       = (tick_cnt_q == TW'(TICK_CYCLES - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    assign press_play = press_q[0];
    assign press_feed = press_q[1];
    assign dec_hit    = tick && (decay_q == CW'(DECAY_TICKS - 1));
    assign play_end   = tick && (pcnt_q == PW'(PLAY_TICKS - 1));

    always_comb begin
        state_d  = state_q;
        health_d = health_q;
        decay_d  = decay_q;
        pcnt_d   = pcnt_q;
        unique case (state_q)
            ALIVE: begin
                if (tick) decay_d = dec_hit ? '0 : decay_q + 1'b1;
                if (dec_hit) begin
                    health_d = (health_q == 2'd0) ? 2'd0 : health_q - 2'd1;
                end
                if (dec_hit && health_q <= 2'd1) begin
                    state_d = DEAD;
                end else if (press_play) begin
                    state_d = PLAY;
                    pcnt_d  = '0;
                end
            end
            PLAY: begin
                if (tick) pcnt_d = play_end ? '0 : pcnt_q + 1'b1;
                if (play_end) begin
                    health_d = (health_q == 2'd3) ? 2'd3 : health_q + 2'd1;
                    state_d  = ALIVE;
                end
            end
            DEAD: begin
                health_d = 2'd0;
            end
            default: begin
                state_d = ALIVE;
            end
        endcase
        // Feed wins over decay and drops a same-cycle play request.
        if (press_feed) begin
            health_d = 2'd3;
            decay_d  = '0;
            if (state_q != PLAY) begin
                state_d = ALIVE;
                pcnt_d  = pcnt_q;
            end
        end
    end

    always_comb begin
        play_d  = (state_d == PLAY);
        timer_d = tick ? ~timer_q : timer_q;
    end

    assign health = health_q;
    assign timer  = timer_q;
    assign play   = play_q;

endmodule
